// File: rtl/parity_frame_codec_if.sv
// ---------------------------------------------------------------------------
// parity_frame_codec_if
// Bundles the parallel-side handshake and the serial-side bit streams of
// parity_frame_codec.
//   odd          : parity mode, 0 = even, 1 = odd
//   tx_data      : word offered for transmission
//   tx_valid     : tx_data is valid
//   tx_ready     : codec can accept a word this cycle
//   tx_bit       : serial output bit
//   tx_bit_valid : tx_bit carries a frame bit
//   tx_last      : tx_bit is the parity bit
//   rx_bit       : serial input bit
//   rx_bit_valid : rx_bit is sampled this cycle
//   rx_data      : last received word
//   rx_done      : one-cycle pulse when a frame completes
//   rx_err       : parity mismatch on the completed frame (only with rx_done)
// The master modport is the data source / link side, the slave modport is
// the codec itself.
// ---------------------------------------------------------------------------
interface parity_frame_codec_if #(
  parameter int WIDTH = 8
) ();

  logic             odd;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_bit;
  logic             tx_bit_valid;
  logic             tx_last;
  logic             rx_bit;
  logic             rx_bit_valid;
  logic [WIDTH-1:0] rx_data;
  logic             rx_done;
  logic             rx_err;

  modport master (
    output odd, tx_data, tx_valid, rx_bit, rx_bit_valid,
    input  tx_ready, tx_bit, tx_bit_valid, tx_last, rx_data, rx_done, rx_err
  );

  modport slave (
    input  odd, tx_data, tx_valid, rx_bit, rx_bit_valid,
    output tx_ready, tx_bit, tx_bit_valid, tx_last, rx_data, rx_done, rx_err
  );

endinterface

// File: rtl/parity_frame_codec.sv
// ---------------------------------------------------------------------------
// parity_frame_codec
// Serial parity encoder/checker for WIDTH-bit words.
// TX: accepts a word on a valid/ready handshake and shifts out WIDTH data
//     bits followed by one parity bit, gap-free when words are back to back.
// RX: reassembles a frame from a (possibly stalled) serial stream,
//     recomputes parity and flags a mismatch with the completion pulse.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : parity_frame_codec_if.slave (handshake, serial and mode signals)
// Parameters:
//   WIDTH     : data bits per frame (2..32)
//   MSB_FIRST : 0 = bit 0 first on the wire, 1 = bit WIDTH-1 first
// ---------------------------------------------------------------------------
module parity_frame_codec #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  parity_frame_codec_if.slave bus
);

  localparam int             CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  TX_LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  RX_PAR_CNT  = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_DATA   = 2'd1,
    TX_PARITY = 2'd2
  } tx_state_t;

  // Parity bit that makes the data+parity ones count match the mode.
  function automatic logic f_parity(input logic [WIDTH-1:0] i_word,
                                    input logic             i_odd);
    return (^i_word) ^ i_odd;
  endfunction

  // Bit that goes on the wire next from a word in transmit order.
  function automatic logic f_head(input logic [WIDTH-1:0] i_word);
    if (MSB_FIRST) begin
      return i_word[WIDTH-1];
    end else begin
      return i_word[0];
    end
  endfunction

  // Drop the bit just sent so the following bit becomes the head.
  function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] i_word);
    if (MSB_FIRST) begin
      return {i_word[WIDTH-2:0], 1'b0};
    end else begin
      return {1'b0, i_word[WIDTH-1:1]};
    end
  endfunction

  // Insert a received bit so that after WIDTH bits the word is in place.
  function automatic logic [WIDTH-1:0] f_insert(input logic [WIDTH-1:0] i_word,
                                                input logic             i_bit);
    if (MSB_FIRST) begin
      return {i_word[WIDTH-2:0], i_bit};
    end else begin
      return {i_bit, i_word[WIDTH-1:1]};
    end
  endfunction

  // ---------------------------------------------------------------- TX ----
  tx_state_t        r_tx_state;
  tx_state_t        w_tx_next;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] w_tx_shift_next;
  logic [CW-1:0]    r_tx_cnt;
  logic             r_tx_par;
  logic             r_tx_ready;
  logic             r_tx_bit;
  logic             r_tx_bit_valid;
  logic             r_tx_last;
  logic             w_tx_load;
  logic             w_tx_ready_next;
  logic             w_tx_bit_next;
  logic             w_tx_bit_valid_next;
  logic             w_tx_last_next;

  // Next-state logic; a word is taken whenever the registered ready is high.
  always_comb begin
    w_tx_next       = r_tx_state;
    w_tx_load       = 1'b0;
    w_tx_shift_next = f_advance(r_tx_shift);
    case (r_tx_state)
      TX_IDLE: begin
        if (bus.tx_valid && r_tx_ready) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_DATA;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == TX_LAST_CNT) begin
          w_tx_next = TX_PARITY;
        end else begin
          w_tx_next = TX_DATA;
        end
      end
      TX_PARITY: begin
        // Loading here keeps back-to-back frames free of idle cycles.
        if (bus.tx_valid && r_tx_ready) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_DATA;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      default: begin
        w_tx_next = TX_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so that
  // all TX outputs leave the block straight from flops.
  always_comb begin
    w_tx_ready_next     = 1'b1;
    w_tx_bit_valid_next = 1'b0;
    w_tx_last_next      = 1'b0;
    w_tx_bit_next       = 1'b0;
    case (w_tx_next)
      TX_IDLE: begin
        w_tx_ready_next     = 1'b1;
        w_tx_bit_valid_next = 1'b0;
        w_tx_last_next      = 1'b0;
        w_tx_bit_next       = 1'b0;
      end
      TX_DATA: begin
        w_tx_ready_next     = 1'b0;
        w_tx_bit_valid_next = 1'b1;
        w_tx_last_next      = 1'b0;
        if (w_tx_load) begin
          w_tx_bit_next = f_head(bus.tx_data);
        end else begin
          w_tx_bit_next = f_head(w_tx_shift_next);
        end
      end
      TX_PARITY: begin
        w_tx_ready_next     = 1'b1;
        w_tx_bit_valid_next = 1'b1;
        w_tx_last_next      = 1'b1;
        w_tx_bit_next       = r_tx_par;
      end
      default: begin
        w_tx_ready_next     = 1'b1;
        w_tx_bit_valid_next = 1'b0;
        w_tx_last_next      = 1'b0;
        w_tx_bit_next       = 1'b0;
      end
    endcase
  end

  // TX state, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state     <= TX_IDLE;
      r_tx_shift     <= {WIDTH{1'b0}};
      r_tx_cnt       <= CNT_ZERO;
      r_tx_par       <= 1'b0;
      r_tx_ready     <= 1'b1;
      r_tx_bit       <= 1'b0;
      r_tx_bit_valid <= 1'b0;
      r_tx_last      <= 1'b0;
    end else begin
      r_tx_state     <= w_tx_next;
      r_tx_ready     <= w_tx_ready_next;
      r_tx_bit       <= w_tx_bit_next;
      r_tx_bit_valid <= w_tx_bit_valid_next;
      r_tx_last      <= w_tx_last_next;
      if (w_tx_load) begin
        // Mode is captured with the word so later odd changes cannot leak in.
        r_tx_shift <= bus.tx_data;
        r_tx_par   <= f_parity(bus.tx_data, bus.odd);
        r_tx_cnt   <= CNT_ZERO;
      end else if (r_tx_state == TX_DATA) begin
        r_tx_shift <= w_tx_shift_next;
        r_tx_cnt   <= r_tx_cnt + CNT_ONE;
      end else begin
        r_tx_shift <= r_tx_shift;
        r_tx_cnt   <= r_tx_cnt;
      end
    end
  end

  assign bus.tx_ready     = r_tx_ready;
  assign bus.tx_bit       = r_tx_bit;
  assign bus.tx_bit_valid = r_tx_bit_valid;
  assign bus.tx_last      = r_tx_last;

  // ---------------------------------------------------------------- RX ----
  logic [CW-1:0]    r_rx_cnt;
  logic [WIDTH-1:0] r_rx_asm;
  logic             r_rx_par;
  logic             r_rx_mode;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_done;
  logic             r_rx_err;
  logic             w_rx_first;
  logic             w_rx_par_slot;
  logic             w_rx_par_next;

  // Frame position decode and running parity of the data bits seen so far.
  always_comb begin
    w_rx_first    = (r_rx_cnt == CNT_ZERO);
    w_rx_par_slot = (r_rx_cnt == RX_PAR_CNT);
    if (w_rx_first) begin
      w_rx_par_next = bus.rx_bit;
    end else begin
      w_rx_par_next = r_rx_par ^ bus.rx_bit;
    end
  end

  // RX frame assembly; cycles without rx_bit_valid leave the frame untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt  <= CNT_ZERO;
      r_rx_asm  <= {WIDTH{1'b0}};
      r_rx_par  <= 1'b0;
      r_rx_mode <= 1'b0;
      r_rx_data <= {WIDTH{1'b0}};
      r_rx_done <= 1'b0;
      r_rx_err  <= 1'b0;
    end else if (bus.rx_bit_valid) begin
      if (w_rx_par_slot) begin
        r_rx_data <= r_rx_asm;
        r_rx_done <= 1'b1;
        r_rx_err  <= (bus.rx_bit != (r_rx_par ^ r_rx_mode));
        r_rx_cnt  <= CNT_ZERO;
      end else begin
        r_rx_asm  <= f_insert(r_rx_asm, bus.rx_bit);
        r_rx_par  <= w_rx_par_next;
        r_rx_cnt  <= r_rx_cnt + CNT_ONE;
        r_rx_done <= 1'b0;
        r_rx_err  <= 1'b0;
        if (w_rx_first) begin
          r_rx_mode <= bus.odd;
        end else begin
          r_rx_mode <= r_rx_mode;
        end
      end
    end else begin
      r_rx_done <= 1'b0;
      r_rx_err  <= 1'b0;
    end
  end

  assign bus.rx_data = r_rx_data;
  assign bus.rx_done = r_rx_done;
  assign bus.rx_err  = r_rx_err;

endmodule

// File: tb/tb_parity_frame_codec.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_codec
// Two codec instances (LSB-first and MSB-first, WIDTH=8) share the stimulus.
// The MSB-first instance always runs in loopback; the LSB-first instance
// runs in loopback with optional bit-flip injection, or is driven directly
// for stalled-stream frames. Expected values come from a word-level model.
// ---------------------------------------------------------------------------
module tb_parity_frame_codec;

  localparam int W = 8;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } rx_exp_t;

  logic clk = 1'b0;
  logic rst;
  logic loop_en;
  logic inj_flip;
  logic drv_bit;
  logic drv_bv;

  int n_cmp = 0;
  int n_mis = 0;

  rx_exp_t      q_l[$];
  rx_exp_t      q_m[$];
  logic [W-1:0] last_l;
  logic [W-1:0] last_m;

  always #5 clk = ~clk;

  parity_frame_codec_if #(.WIDTH(W)) if_l ();
  parity_frame_codec_if #(.WIDTH(W)) if_m ();

  parity_frame_codec #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if_l.slave)
  );

  parity_frame_codec #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (if_m.slave)
  );

  assign if_l.rx_bit       = loop_en ? (if_l.tx_bit ^ inj_flip) : drv_bit;
  assign if_l.rx_bit_valid = loop_en ? if_l.tx_bit_valid : drv_bv;
  assign if_m.rx_bit       = if_m.tx_bit;
  assign if_m.rx_bit_valid = if_m.tx_bit_valid;

  // ---------------------------------------------------------------- model
  function automatic logic m_parity(input logic [W-1:0] w, input logic md);
    return 1'(($countones(w) + int'(md)) % 2);
  endfunction

  // Frame bit i (0..W-1 data, W parity) as it should appear on the wire.
  function automatic logic m_bit(input logic [W-1:0] w, input logic md,
                                 input bit msb, input int i);
    if (i == W) return m_parity(w, md);
    return w[msb ? (W - 1 - i) : i];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_word(input logic [W-1:0] w, input logic md);
    if_l.tx_data = w;
    if_m.tx_data = w;
    if_l.odd     = md;
    if_m.odd     = md;
  endtask

  task automatic set_valid(input logic v);
    if_l.tx_valid = v;
    if_m.tx_valid = v;
  endtask

  task automatic check_reset();
    check_eq("l_rst_ready", if_l.tx_ready, 1);
    check_eq("l_rst_bv",    if_l.tx_bit_valid, 0);
    check_eq("l_rst_last",  if_l.tx_last, 0);
    check_eq("l_rst_bit",   if_l.tx_bit, 0);
    check_eq("l_rst_done",  if_l.rx_done, 0);
    check_eq("l_rst_err",   if_l.rx_err, 0);
    check_eq("l_rst_data",  if_l.rx_data, 0);
    check_eq("m_rst_ready", if_m.tx_ready, 1);
    check_eq("m_rst_bv",    if_m.tx_bit_valid, 0);
    check_eq("m_rst_last",  if_m.tx_last, 0);
    check_eq("m_rst_done",  if_m.rx_done, 0);
    check_eq("m_rst_data",  if_m.rx_data, 0);
  endtask

  task automatic check_tx(input int i, input logic [W-1:0] w, input logic md,
                          input logic exp_ready);
    check_eq("l_tx_bv",    if_l.tx_bit_valid, 1);
    check_eq("l_tx_bit",   if_l.tx_bit, m_bit(w, md, 1'b0, i));
    check_eq("l_tx_last",  if_l.tx_last, (i == W));
    check_eq("l_tx_ready", if_l.tx_ready, exp_ready);
    check_eq("m_tx_bv",    if_m.tx_bit_valid, 1);
    check_eq("m_tx_bit",   if_m.tx_bit, m_bit(w, md, 1'b1, i));
    check_eq("m_tx_last",  if_m.tx_last, (i == W));
    check_eq("m_tx_ready", if_m.tx_ready, exp_ready);
  endtask

  // One frame through both TX paths; flip_idx >= 0 corrupts that data bit
  // on the LSB-first loopback wire. Entered and left at posedge+1, TX idle.
  task automatic tx_frame(input logic [W-1:0] w, input logic md, input int flip_idx);
    logic [W-1:0] mask;
    mask = '0;
    if (flip_idx >= 0) mask[flip_idx] = 1'b1;
    set_word(w, md);
    set_valid(1'b1);
    @(negedge clk);
    check_eq("l_ready_idle", if_l.tx_ready, 1);
    check_eq("m_ready_idle", if_m.tx_ready, 1);
    @(posedge clk); #1;
    set_valid(1'b0);
    q_m.push_back('{err: 1'b0, data: w});
    if (loop_en) q_l.push_back('{err: (flip_idx >= 0), data: w ^ mask});
    for (int i = 0; i <= W; i++) begin
      inj_flip = (i == flip_idx);
      if (i >= 1) begin
        // The frame in flight must ignore these.
        set_word(W'($urandom), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      check_tx(i, w, md, (i == W));
      @(posedge clk); #1;
    end
    inj_flip = 1'b0;
  endtask

  task automatic back_to_back();
    logic [W-1:0] words [3];
    int f;
    int i;
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h01;
    for (int k = 0; k < 3; k++) begin
      q_l.push_back('{err: 1'b0, data: words[k]});
      q_m.push_back('{err: 1'b0, data: words[k]});
    end
    set_word(words[0], 1'b0);
    set_valid(1'b1);
    @(negedge clk);
    check_eq("b2b_l_ready_pre", if_l.tx_ready, 1);
    check_eq("b2b_m_ready_pre", if_m.tx_ready, 1);
    @(posedge clk); #1;
    for (int c = 0; c < 3 * (W + 1); c++) begin
      f = c / (W + 1);
      i = c % (W + 1);
      if (i == 0) begin
        if (f < 2) set_word(words[f + 1], 1'b0);
        else       set_valid(1'b0);
      end
      @(negedge clk);
      check_tx(i, words[f], 1'b0, (i == W));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_eq("b2b_l_bv_after", if_l.tx_bit_valid, 0);
    check_eq("b2b_m_bv_after", if_m.tx_bit_valid, 0);
    @(posedge clk); #1;
  endtask

  // Drive a correct frame straight into the LSB-first RX, one valid bit
  // every third cycle.
  task automatic stall_frame(input logic [W-1:0] w, input logic md);
    loop_en = 1'b0;
    q_l.push_back('{err: 1'b0, data: w});
    for (int i = 0; i <= W; i++) begin
      repeat (2) begin
        drv_bv  = 1'b0;
        drv_bit = 1'($urandom_range(0, 1));
        if_l.odd = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      drv_bv  = 1'b1;
      drv_bit = m_bit(w, md, 1'b0, i);
      if_l.odd = (i == 0) ? md : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drv_bv = 1'b0;
    @(posedge clk); #1;
    loop_en = 1'b1;
  endtask

  task automatic reset_mid();
    set_word(8'hC3, 1'b0);
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // RX scoreboards: each completion must match the oldest expected frame,
  // and between completions rx_err stays low and rx_data holds.
  always @(negedge clk) begin
    rx_exp_t e;
    if (rst) begin
      last_l = '0;
      last_m = '0;
    end else begin
      if (if_l.rx_done) begin
        check_eq("l_rx_pending", 32'(q_l.size() > 0), 1);
        if (q_l.size() > 0) begin
          e = q_l.pop_front();
          check_eq("l_rx_data", if_l.rx_data, e.data);
          check_eq("l_rx_err",  if_l.rx_err,  e.err);
          last_l = e.data;
        end
      end else begin
        check_eq("l_rx_err_idle",  if_l.rx_err, 0);
        check_eq("l_rx_data_hold", if_l.rx_data, last_l);
      end
      if (if_m.rx_done) begin
        check_eq("m_rx_pending", 32'(q_m.size() > 0), 1);
        if (q_m.size() > 0) begin
          e = q_m.pop_front();
          check_eq("m_rx_data", if_m.rx_data, e.data);
          check_eq("m_rx_err",  if_m.rx_err,  e.err);
          last_m = e.data;
        end
      end else begin
        check_eq("m_rx_err_idle",  if_m.rx_err, 0);
        check_eq("m_rx_data_hold", if_m.rx_data, last_m);
      end
    end
  end

  initial begin
    rst      = 1'b0;
    loop_en  = 1'b1;
    inj_flip = 1'b0;
    drv_bit  = 1'b0;
    drv_bv   = 1'b0;
    set_word('0, 1'b0);
    set_valid(1'b0);
    #2 rst = 1'b1;
    #1 check_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    tx_frame(8'hA5, 1'b0, -1);
    tx_frame(8'hA5, 1'b1, -1);
    tx_frame(8'h01, 1'b0, -1);
    back_to_back();

    for (int md = 0; md < 2; md++) begin
      for (int w = 0; w < 256; w++) begin
        tx_frame(W'(w), 1'(md), -1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    tx_frame(8'h3C, 1'b0, int'($urandom_range(0, W - 1)));
    tx_frame(8'h3C, 1'b1, int'($urandom_range(0, W - 1)));
    @(posedge clk); #1;
    stall_frame(8'h3C, 1'($urandom_range(0, 1)));
    @(posedge clk); #1;

    reset_mid();
    tx_frame(8'h5A, 1'b0, -1);
    @(negedge clk);
    check_eq("l_rx_5a_done", if_l.rx_done, 1);
    check_eq("l_rx_5a_data", if_l.rx_data, 8'h5A);
    check_eq("l_rx_5a_err",  if_l.rx_err, 0);
    check_eq("m_rx_5a_data", if_m.rx_data, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    check_eq("l_rx_q_empty", q_l.size(), 0);
    check_eq("m_rx_q_empty", q_m.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
